xnor_pop_accum: RTL and testbench

Streaming, pipelined XNOR-popcount accumulator for binarized dot products. Each beat takes two WIDTH-bit vectors, forms per-bit XNOR, reduces it through a registered halving adder tree, and accumulates beats until in_last. It then presents both the raw match count and the bipolar (±1) dot product. It is the parametrised, pipelined successor of the 128-bit combinational XNOR-popcount tree and sits between the binarized activation/weight buffers and the threshold/activation unit.

---
 rtl/xnor_pop_accum_if.sv | 31 +++
 rtl/xnor_pop_accum.sv | 108 ++++++++++
 tb/tb_xnor_pop_accum.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/xnor_pop_accum_if.sv
// Beat/result bus for the XNOR-popcount accumulator.
// master drives beats and consumes results; slave is the accumulator.
interface xnor_pop_accum_if #(
    parameter int WIDTH   = 128,
    parameter int BEATS_W = 8
);
    localparam int POP_W = $clog2(WIDTH) + 1;
    localparam int ACC_W = POP_W + BEATS_W;

    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [WIDTH-1:0]   inx;
    logic [WIDTH-1:0]   iny;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_pop;
    logic [ACC_W:0]     out_dot;
    logic [BEATS_W-1:0] out_beats;
    logic               out_ovf;

    modport master (
        output in_valid, in_last, inx, iny, out_ready,
        input  in_ready, out_valid, out_pop, out_dot, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_last, inx, iny, out_ready,
        output in_ready, out_valid, out_pop, out_dot, out_beats, out_ovf
    );
endinterface

// File: rtl/xnor_pop_accum.sv
// Pipelined XNOR-popcount accumulator for binarized dot products.
// Stage 0 registers x ~^ y, T registered halving adder levels reduce it to
// one count, then the accumulator sums beats until last (or MAXB beats) and
// presents match count and bipolar dot product. One global enable freezes
// the whole pipe while a result is held and not consumed.
module xnor_pop_accum #(
    parameter int WIDTH   = 128,
    parameter int BEATS_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    xnor_pop_accum_if.slave bus
);
    localparam int T     = $clog2(WIDTH);
    localparam int POP_W = T + 1;
    localparam int ACC_W = POP_W + BEATS_W;
    localparam logic [BEATS_W-1:0] MAXB = '1;

    logic en;
    logic [T:0] vld_pipe_q, last_pipe_q;

    logic [ACC_W-1:0]   acc_q, acc_sum;
    logic [BEATS_W-1:0] beats_q, beats_inc;
    logic               close;
    logic [ACC_W:0]     dot_d;
    logic               ovf_d;

    logic               out_valid_q, out_ovf_q;
    logic [ACC_W-1:0]   out_pop_q;
    logic [ACC_W:0]     out_dot_q;
    logic [BEATS_W-1:0] out_beats_q;

    assign en = !out_valid_q || bus.out_ready;

    // Level l holds WIDTH>>l fields of l+1 bits; level 0 is the raw XNOR.
    for (genvar l = 0; l <= T; l++) begin : lvl
        localparam int FW = l + 1;
        localparam int N  = WIDTH >> l;
        logic [N*FW-1:0] fld_d, fld_q;

        if (l == 0) begin : g_xnor
            assign fld_d = bus.inx ~^ bus.iny;
        end else begin : g_add
            for (genvar j = 0; j < N; j++) begin : g_fld
                assign fld_d[j*FW +: FW] = FW'(lvl[l-1].fld_q[2*j*l +: l])
                                         + FW'(lvl[l-1].fld_q[(2*j+1)*l +: l]);
            end
        end

        // Tree level register, frozen with the rest of the pipe.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)     fld_q <= '0;
            else if (en) fld_q <= fld_d;
        end
    end

    // Valid and last tags travel alongside the tree levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else if (en) begin
            vld_pipe_q  <= {vld_pipe_q[T-1:0], bus.in_valid};
            last_pipe_q <= {last_pipe_q[T-1:0], bus.in_valid && bus.in_last};
        end
    end

    // A vector closes on its last beat or when the beat counter would hit MAXB.
    assign acc_sum   = acc_q + ACC_W'(lvl[T].fld_q);
    assign beats_inc = beats_q + 1'b1;
    assign close     = vld_pipe_q[T] && (last_pipe_q[T] || beats_inc == MAXB);
    assign ovf_d     = (beats_inc == MAXB) && !last_pipe_q[T];
    // dot = 2*pop - WIDTH*beats; modular subtraction yields two's complement.
    assign dot_d     = {acc_sum, 1'b0} - ((ACC_W+1)'(beats_inc) << T);

    // Accumulate beats and load/hold the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            out_pop_q   <= '0;
            out_dot_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (en) begin
            if (vld_pipe_q[T]) begin
                acc_q   <= close ? '0 : acc_sum;
                beats_q <= close ? '0 : beats_inc;
            end
            // en implies the held result (if any) is consumed this edge.
            out_valid_q <= close;
            if (close) begin
                out_pop_q   <= acc_sum;
                out_dot_q   <= dot_d;
                out_beats_q <= beats_inc;
                out_ovf_q   <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pop   = out_pop_q;
    assign bus.out_dot   = out_dot_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_xnor_pop_accum.sv
// Directed bench: a behavioural model pushes expected results into a queue
// as beats are accepted; monitors pop and compare on each output handshake.
module tb_xnor_pop_accum;
    typedef struct {
        logic [63:0] pop;
        logic [63:0] dot;
        logic [63:0] beats;
        logic [63:0] ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xnor_pop_accum_if #(.WIDTH(128), .BEATS_W(8)) if1 ();
    xnor_pop_accum_if #(.WIDTH(128), .BEATS_W(2)) if2 ();

    xnor_pop_accum #(.WIDTH(128), .BEATS_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    xnor_pop_accum #(.WIDTH(128), .BEATS_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int   nvec = 0;
    int   nmis = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   m_acc = 0;
    int   m_beats = 0;
    logic win = 1'b0;
    int   rdy_low = 0;
    logic stall_seen = 1'b0;
    int   lat;

    localparam logic [127:0] ONES = '1;
    localparam logic [127:0] HALF = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one beat to dut1 until accepted, then update the model.
    task automatic send1(input logic [127:0] x, input logic [127:0] y, input logic last);
        int   n = 0;
        logic ok = 1'b0;
        exp_t e;
        while (!ok && n < 200) begin
            @(negedge clk);
            if1.in_valid = 1'b1; if1.inx = x; if1.iny = y; if1.in_last = last;
            #1 ok = if1.in_ready;
            @(posedge clk);
            #1 n++;
        end
        if1.in_valid = 1'b0;
        if (!ok) chk("send1 timeout", 64'd0, 64'd1);
        else begin
            m_acc += $countones(~(x ^ y));
            m_beats++;
            if (last || m_beats == 255) begin
                e.pop   = 64'(m_acc);
                e.dot   = 64'(2 * m_acc - 128 * m_beats) & 64'h1FFFF;
                e.beats = 64'(m_beats);
                e.ovf   = 64'(m_beats == 255 && !last);
                q1.push_back(e);
                m_acc = 0;
                m_beats = 0;
            end
        end
    endtask

    task automatic send2(input logic [127:0] x, input logic [127:0] y, input logic last);
        int   n = 0;
        logic ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if2.in_valid = 1'b1; if2.inx = x; if2.iny = y; if2.in_last = last;
            #1 ok = if2.in_ready;
            @(posedge clk);
            #1 n++;
        end
        if2.in_valid = 1'b0;
        if (!ok) chk("send2 timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain q1", 64'(q1.size()), 64'd0);
        chk("drain q2", 64'(q2.size()), 64'd0);
    endtask

    // dut1 result monitor.
    always @(negedge clk) begin
        exp_t e;
        if (win && !if1.in_ready) rdy_low++;
        if (!if1.in_ready) stall_seen = 1'b1;
        if (!rst && if1.out_valid && if1.out_ready) begin
            if (q1.size() == 0) chk("dut1 unexpected result", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                chk("dut1 pop",   64'(if1.out_pop),   e.pop);
                chk("dut1 dot",   64'(if1.out_dot),   e.dot);
                chk("dut1 beats", 64'(if1.out_beats), e.beats);
                chk("dut1 ovf",   64'(if1.out_ovf),   e.ovf);
            end
        end
    end

    // dut2 result monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if2.out_valid && if2.out_ready) begin
            if (q2.size() == 0) chk("dut2 unexpected result", 64'd1, 64'd0);
            else begin
                e = q2.pop_front();
                chk("dut2 pop",   64'(if2.out_pop),   e.pop);
                chk("dut2 dot",   64'(if2.out_dot),   e.dot);
                chk("dut2 beats", 64'(if2.out_beats), e.beats);
                chk("dut2 ovf",   64'(if2.out_ovf),   e.ovf);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if1.in_valid = 0; if1.in_last = 0; if1.inx = '0; if1.iny = '0; if1.out_ready = 1;
        if2.in_valid = 0; if2.in_last = 0; if2.inx = '0; if2.iny = '0; if2.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",  64'(if1.in_ready),  64'd1);
        chk("reset out_valid", 64'(if1.out_valid), 64'd0);
        chk("reset out_pop",   64'(if1.out_pop),   64'd0);
        chk("reset out_dot",   64'(if1.out_dot),   64'd0);
        chk("reset out_beats", 64'(if1.out_beats), 64'd0);
        chk("reset out_ovf",   64'(if1.out_ovf),   64'd0);
        @(negedge clk) rst = 1'b0;

        // Single all-match beat; out_valid rises on the 9th register edge
        // counting the accepting edge (stage 0 + 7 tree levels + accumulate).
        send1(ONES, ONES, 1'b1);
        lat = 1;
        while (!if1.out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 64'(lat), 64'd9);
        drain();

        // Three beats: no matches, full match, half match -> pop 192, dot 0.
        send1(ONES, ~ONES, 1'b0);
        send1(HALF, HALF, 1'b0);
        send1(ONES, HALF, 1'b1);
        drain();

        // Back-to-back single-beat vectors; in_ready must never drop.
        win = 1'b1;
        for (int i = 0; i < 20; i++) send1(rnd128(), rnd128(), 1'b1);
        win = 1'b0;
        chk("b2b in_ready low cycles", 64'(rdy_low), 64'd0);
        drain();

        // Stall: out_ready low for 20 cycles while 30 beats are offered.
        @(posedge clk);
        #1 if1.out_ready = 1'b0;
        stall_seen = 1'b0;
        fork
            for (int i = 0; i < 30; i++) send1(rnd128(), rnd128(), (i % 3) == 2);
            begin
                repeat (20) @(posedge clk);
                #1 if1.out_ready = 1'b1;
            end
        join
        chk("stall in_ready dropped", 64'(stall_seen), 64'd1);
        drain();

        // Reset mid-vector: beats 1-2 are discarded.
        send1(ONES, ONES, 1'b0);
        send1(ONES, ONES, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset out_pop",   64'(if1.out_pop),   64'd0);
        chk("midreset out_dot",   64'(if1.out_dot),   64'd0);
        chk("midreset out_beats", 64'(if1.out_beats), 64'd0);
        chk("midreset out_valid", 64'(if1.out_valid), 64'd0);
        chk("midreset in_ready",  64'(if1.in_ready),  64'd1);
        m_acc = 0;
        m_beats = 0;
        @(negedge clk) rst = 1'b0;
        send1(ONES, ONES, 1'b0);
        send1(ONES, ONES, 1'b0);
        send1(ONES, ONES, 1'b0);
        send1(ONES, ~ONES, 1'b1);
        drain();

        // BEATS_W=2: forced close at 3 beats, then a 2-beat tail closed by last.
        q2.push_back('{pop: 64'd384, dot: 64'd384, beats: 64'd3, ovf: 64'd1});
        q2.push_back('{pop: 64'd256, dot: 64'd256, beats: 64'd2, ovf: 64'd0});
        for (int i = 0; i < 5; i++) send2(ONES, ONES, i == 4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
